// File: rtl/treehash_ctrl.sv
// treehash_ctrl: streaming Merkle tree-hash controller.
// Leaves arrive one at a time and are merged with equal-height nodes held on
// an external node stack. Heights of the stacked nodes live in a small
// internal stack. The final root is emitted as a one-cycle pulse.
// Optional authentication-path output is enabled by defining
// TREEHASH_AUTH_PATH_EN.
module treehash_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int HEIGHT     = 4,
  parameter int STK_LAT    = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  output logic                    o_busy,
  input  logic                    i_leaf_valid,
  output logic                    o_leaf_ready,
  input  logic [DATA_WIDTH-1:0]   i_leaf_data,
  output logic                    o_hash_req_valid,
  input  logic                    i_hash_req_ready,
  output logic [DATA_WIDTH-1:0]   o_hash_left,
  output logic [DATA_WIDTH-1:0]   o_hash_right,
  input  logic                    i_hash_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   i_hash_rsp_data,
  output logic                    o_stk_push,
  output logic                    o_stk_pop,
  output logic [DATA_WIDTH-1:0]   o_stk_wdata,
  input  logic [DATA_WIDTH-1:0]   i_stk_rdata,
  output logic                    o_root_valid,
  output logic [DATA_WIDTH-1:0]   o_root_data
`ifdef TREEHASH_AUTH_PATH_EN
  ,
  input  logic [HEIGHT-1:0]       i_auth_idx,
  output logic                    o_auth_valid,
  output logic [$clog2(HEIGHT):0] o_auth_height,
  output logic [DATA_WIDTH-1:0]   o_auth_data
`endif
);

  localparam int HW  = $clog2(HEIGHT) + 1;
  localparam int PW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int LCW = HEIGHT + 1;
  localparam int LW  = $clog2(STK_LAT + 1);
  localparam logic [HW-1:0] HMAX   = HW'(HEIGHT);
  localparam logic [LW-1:0] LATMAX = LW'(STK_LAT);

  typedef enum logic [3:0] {
    S_IDLE, S_LEAF, S_CHECK, S_POP, S_POP_WAIT, S_HREQ, S_HWAIT, S_PUSH, S_DONE
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_cur;
  logic [HW-1:0]         r_cur_h;
  logic [DATA_WIDTH-1:0] r_left;
  logic [HW-1:0]         r_hstk [0:HEIGHT-1];
  logic [HW-1:0]         r_hptr;
  logic [LCW-1:0]        r_leaf_cnt;
  logic [LW-1:0]         r_lat;
  logic                  r_busy;
  logic                  r_leaf_ready;
  logic                  r_hreq_valid;
  logic                  r_stk_push;
  logic                  r_stk_pop;
  logic [DATA_WIDTH-1:0] r_stk_wdata;
  logic                  r_root_valid;
  logic [DATA_WIDTH-1:0] r_root_data;

  logic                  w_hstk_empty;
  logic [HW-1:0]         w_top;
  logic [HW-1:0]         w_nh;

  assign w_hstk_empty = (r_hptr == '0);
  assign w_top        = r_hstk[PW'(r_hptr - HW'(1))];
  assign w_nh         = r_cur_h + HW'(1);

`ifdef TREEHASH_AUTH_PATH_EN
  logic [HEIGHT-1:0]     r_auth_idx;
  logic                  r_auth_valid;
  logic [HW-1:0]         r_auth_height;
  logic [DATA_WIDTH-1:0] r_auth_data;
  logic [LCW-1:0]        w_aidx_ext;
  logic                  w_leaf_hit;
  logic                  w_hash_hit;

  // The node just formed is the sibling of the target's ancestor at its height;
  // r_leaf_cnt is still the index of the most recent leaf when a merge completes.
  assign w_aidx_ext = {1'b0, r_auth_idx};
  assign w_leaf_hit = (r_leaf_cnt == (w_aidx_ext ^ LCW'(1)));
  assign w_hash_hit = (w_nh < HMAX) &&
                      ((r_leaf_cnt >> w_nh) == ((w_aidx_ext >> w_nh) ^ LCW'(1)));

  assign o_auth_valid  = r_auth_valid;
  assign o_auth_height = r_auth_height;
  assign o_auth_data   = r_auth_data;
`endif

  assign o_busy           = r_busy;
  assign o_leaf_ready     = r_leaf_ready;
  assign o_hash_req_valid = r_hreq_valid;
  assign o_hash_left      = r_left;
  assign o_hash_right     = r_cur;
  assign o_stk_push       = r_stk_push;
  assign o_stk_pop        = r_stk_pop;
  assign o_stk_wdata      = r_stk_wdata;
  assign o_root_valid     = r_root_valid;
  assign o_root_data      = r_root_data;

  // Control FSM; outputs are registered and set on entry to the state that owns them.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_cur        <= '0;
      r_cur_h      <= '0;
      r_left       <= '0;
      r_hptr       <= '0;
      r_leaf_cnt   <= '0;
      r_lat        <= '0;
      r_busy       <= 1'b0;
      r_leaf_ready <= 1'b0;
      r_hreq_valid <= 1'b0;
      r_stk_push   <= 1'b0;
      r_stk_pop    <= 1'b0;
      r_stk_wdata  <= '0;
      r_root_valid <= 1'b0;
      r_root_data  <= '0;
`ifdef TREEHASH_AUTH_PATH_EN
      r_auth_idx    <= '0;
      r_auth_valid  <= 1'b0;
      r_auth_height <= '0;
      r_auth_data   <= '0;
`endif
    end else begin
      r_stk_push   <= 1'b0;
      r_stk_pop    <= 1'b0;
      r_root_valid <= 1'b0;
`ifdef TREEHASH_AUTH_PATH_EN
      r_auth_valid <= 1'b0;
`endif
      case (r_state)
        // DONE already has busy low, so a new start is accepted there too.
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_busy       <= 1'b1;
            r_leaf_ready <= 1'b1;
            r_leaf_cnt   <= '0;
            r_hptr       <= '0;
`ifdef TREEHASH_AUTH_PATH_EN
            r_auth_idx   <= i_auth_idx;
`endif
            r_state      <= S_LEAF;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LEAF: begin
          if (i_leaf_valid) begin
            r_leaf_ready <= 1'b0;
            r_cur        <= i_leaf_data;
            r_cur_h      <= '0;
`ifdef TREEHASH_AUTH_PATH_EN
            if (w_leaf_hit) begin
              r_auth_valid  <= 1'b1;
              r_auth_height <= '0;
              r_auth_data   <= i_leaf_data;
            end
`endif
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!w_hstk_empty && (w_top == r_cur_h)) begin
            r_stk_pop <= 1'b1;
            r_hptr    <= r_hptr - HW'(1);
            r_state   <= S_POP;
          end else if (r_cur_h == HMAX) begin
            r_root_valid <= 1'b1;
            r_root_data  <= r_cur;
            r_busy       <= 1'b0;
            r_state      <= S_DONE;
          end else begin
            r_stk_push          <= 1'b1;
            r_stk_wdata         <= r_cur;
            r_hstk[PW'(r_hptr)] <= r_cur_h;
            r_hptr              <= r_hptr + HW'(1);
            r_state             <= S_PUSH;
          end
        end
        S_POP: begin
          r_lat   <= LW'(1);
          r_state <= S_POP_WAIT;
        end
        S_POP_WAIT: begin
          if (r_lat == LATMAX) begin
            r_left       <= i_stk_rdata;
            r_hreq_valid <= 1'b1;
            r_state      <= S_HREQ;
          end else begin
            r_lat <= r_lat + LW'(1);
          end
        end
        S_HREQ: begin
          if (i_hash_req_ready) begin
            r_hreq_valid <= 1'b0;
            r_state      <= S_HWAIT;
          end
        end
        S_HWAIT: begin
          if (i_hash_rsp_valid) begin
            r_cur   <= i_hash_rsp_data;
            r_cur_h <= w_nh;
`ifdef TREEHASH_AUTH_PATH_EN
            if (w_hash_hit) begin
              r_auth_valid  <= 1'b1;
              r_auth_height <= w_nh;
              r_auth_data   <= i_hash_rsp_data;
            end
`endif
            r_state <= S_CHECK;
          end
        end
        S_PUSH: begin
          r_leaf_cnt   <= r_leaf_cnt + LCW'(1);
          r_leaf_ready <= 1'b1;
          r_state      <= S_LEAF;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_treehash_ctrl.sv
// Bench for treehash_ctrl (HEIGHT=3, STK_LAT=2, hash H(l,r)=l+2r).
// Emulates the leaf source, hash unit and external node stack, and checks the
// DUT against a level-by-level tree model. Auth checks apply when
// TREEHASH_AUTH_PATH_EN is defined.
module tb_treehash_ctrl;

  localparam int H   = 3;
  localparam int N   = 1 << H;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n, start, leaf_valid, hreq_ready, rsp_valid;
  logic [31:0] leaf_data, rsp_data, stk_rdata;
  logic        busy, leaf_ready, hreq_valid, stk_push, stk_pop, root_valid;
  logic [31:0] hash_left, hash_right, stk_wdata, root_data;
`ifdef TREEHASH_AUTH_PATH_EN
  logic [H-1:0]        auth_idx;
  logic                auth_valid;
  logic [$clog2(H):0]  auth_height;
  logic [31:0]         auth_data;
`endif

  always #5 clk = ~clk;

  treehash_ctrl #(.DATA_WIDTH(32), .HEIGHT(H), .STK_LAT(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_busy(busy),
    .i_leaf_valid(leaf_valid), .o_leaf_ready(leaf_ready), .i_leaf_data(leaf_data),
    .o_hash_req_valid(hreq_valid), .i_hash_req_ready(hreq_ready),
    .o_hash_left(hash_left), .o_hash_right(hash_right),
    .i_hash_rsp_valid(rsp_valid), .i_hash_rsp_data(rsp_data),
    .o_stk_push(stk_push), .o_stk_pop(stk_pop), .o_stk_wdata(stk_wdata),
    .i_stk_rdata(stk_rdata), .o_root_valid(root_valid), .o_root_data(root_data)
`ifdef TREEHASH_AUTH_PATH_EN
    , .i_auth_idx(auth_idx), .o_auth_valid(auth_valid),
    .o_auth_height(auth_height), .o_auth_data(auth_data)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] lv [0:N-1];
  logic [31:0] nodes [0:H][0:N-1];
  logic [31:0] exp_pl[$];
  logic [31:0] exp_pr[$];
  logic [31:0] exp_root;
  logic [31:0] exp_auth [0:H-1];
  int unsigned aidx_v;

  function automatic logic [31:0] hfn(input logic [31:0] l, input logic [31:0] r);
    return l + (r << 1);
  endfunction

  // Node values per level; merges appear in the order their last leaf arrives,
  // lower levels first.
  task automatic build_model();
    for (int i = 0; i < N; i++) nodes[0][i] = lv[i];
    for (int l = 1; l <= H; l++)
      for (int i = 0; i < (N >> l); i++)
        nodes[l][i] = hfn(nodes[l-1][2*i], nodes[l-1][2*i+1]);
    exp_pl.delete();
    exp_pr.delete();
    for (int j = 0; j < N; j++)
      for (int l = 1; l <= H; l++)
        if (((j + 1) % (1 << l)) == 0) begin
          int k;
          k = ((j + 1) >> l) - 1;
          exp_pl.push_back(nodes[l-1][2*k]);
          exp_pr.push_back(nodes[l-1][2*k+1]);
        end
    exp_root = nodes[H][0];
    for (int h = 0; h < H; h++) exp_auth[h] = nodes[h][(aidx_v >> h) ^ 1];
  endtask

  // ---------------- environment ----------------
  int unsigned cyc = 0;
  logic [31:0] lq[$];
  bit          gap_mode = 0;
  int          stall_cycles = 0;
  int          wait_left = 0;
  bit          in_req = 0;
  int          rsp_dly = 2;
  int          rsp_cnt = -1;
  logic [31:0] rsp_val = '0;
  logic [31:0] stk[$];
  bit          pop_pend = 0;
  int unsigned pop_cyc = 0;
  logic [31:0] pop_val = '0;
  int          n_leaf = 0, n_hreq = 0, n_push = 0, n_pop = 0, n_root = 0, n_auth = 0;
  bit          auth_seen [0:H-1];
  logic [63:0] hist[$];
  logic [31:0] last_root = '0;

  initial begin
    leaf_valid = 0; leaf_data = '0; hreq_ready = 0; rsp_valid = 0; rsp_data = '0;
    stk_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        chk("push_pop_exclusive", 64'(stk_push & stk_pop), 0);
        chk("leaf_ready_only_busy", 64'(leaf_ready & ~busy), 0);
        if (stk_push) begin
          stk.push_back(stk_wdata);
          n_push++;
          chk("stack_depth_le_H", 64'(stk.size() <= H), 1);
        end
        if (stk_pop) begin
          n_pop++;
          chk("pop_nonempty", 64'(stk.size() > 0), 1);
          pop_val  = (stk.size() > 0) ? stk.pop_back() : 32'hDEAD_DEAD;
          pop_pend = 1;
          pop_cyc  = cyc;
        end
      end
      // popped value is presented only in the cycle it must be sampled
      if (pop_pend && cyc == pop_cyc + LAT) begin
        stk_rdata = pop_val;
        pop_pend  = 0;
      end else begin
        stk_rdata = 32'hBAD0_0000 ^ cyc;
      end
      if (rsp_cnt > 0) rsp_cnt--;
      if (rsp_cnt == 0) begin
        rsp_valid = 1; rsp_data = rsp_val; rsp_cnt = -1;
      end else begin
        rsp_valid = 0; rsp_data = 32'h5EED_0000 ^ cyc;
      end
      hreq_ready = 0;
      if (rst_n && hreq_valid) begin
        if (exp_pl.size() == 0) begin
          chk("hash_req_unexpected", 1, 0);
        end else begin
          chk("hash_left", hash_left, exp_pl[0]);
          chk("hash_right", hash_right, exp_pr[0]);
          if (!in_req) begin in_req = 1; wait_left = stall_cycles; end
          if (wait_left > 0) begin
            wait_left--;
          end else begin
            hreq_ready = 1;
            in_req = 0;
            n_hreq++;
            hist.push_back({hash_left, hash_right});
            rsp_val = hfn(exp_pl[0], exp_pr[0]);
            rsp_cnt = rsp_dly;
            void'(exp_pl.pop_front());
            void'(exp_pr.pop_front());
          end
        end
      end
      if (lq.size() > 0 && (!gap_mode || (cyc % 3) != 0)) begin
        leaf_valid = 1; leaf_data = lq[0];
      end else begin
        leaf_valid = 0; leaf_data = 32'hFEED_0000 ^ cyc;
      end
      if (rst_n && leaf_ready && leaf_valid) begin
        void'(lq.pop_front());
        n_leaf++;
      end
      if (rst_n && root_valid) begin
        n_root++;
        last_root = root_data;
        chk("root_data", root_data, exp_root);
        chk("busy_low_at_root", 64'(busy), 0);
        chk("stack_empty_at_root", 64'(stk.size()), 0);
      end
`ifdef TREEHASH_AUTH_PATH_EN
      if (rst_n && auth_valid) begin
        n_auth++;
        chk("auth_height_lt_H", 64'(int'(auth_height) < H), 1);
        if (int'(auth_height) < H) begin
          chk("auth_data", auth_data, exp_auth[int'(auth_height)]);
          auth_seen[int'(auth_height)] = 1;
        end
      end
`endif
    end
  end

  task automatic setup_tree(input bit gap, input int stall, input int unsigned aidx);
    aidx_v = aidx;
    build_model();
    n_leaf = 0; n_hreq = 0; n_push = 0; n_pop = 0; n_root = 0; n_auth = 0;
    for (int h = 0; h < H; h++) auth_seen[h] = 0;
    hist.delete();
    gap_mode = gap;
    stall_cycles = stall;
    lq.delete();
    for (int i = 0; i < N; i++) lq.push_back(lv[i]);
`ifdef TREEHASH_AUTH_PATH_EN
    auth_idx = H'(aidx);
`endif
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    chk("busy_after_start", 64'(busy), 1);
  endtask

  task automatic run_tree(input bit gap, input int stall, input int unsigned aidx,
                          input bit poke);
    int t;
    setup_tree(gap, stall, aidx);
    t = 0;
    while (n_root == 0 && t < 3000) begin
      @(negedge clk);
      t++;
      if (poke && (t == 20 || t == 45)) begin
        start = 1;
        chk("busy_when_start_poked", 64'(busy), 1);
      end else begin
        start = 0;
      end
    end
    start = 0;
    if (n_root == 0) chk("root_timeout", 0, 1);
    repeat (5) @(negedge clk);
    chk("root_pulse_count", 64'(n_root), 1);
    chk("leaf_count", 64'(n_leaf), N);
    chk("hash_req_count", 64'(n_hreq), N - 1);
    chk("push_count", 64'(n_push), N - 1);
    chk("pop_count", 64'(n_pop), N - 1);
    chk("leaves_left", 64'(lq.size()), 0);
    chk("pairs_left", 64'(exp_pl.size()), 0);
    chk("busy_idle_after", 64'(busy), 0);
`ifdef TREEHASH_AUTH_PATH_EN
    chk("auth_pulse_count", 64'(n_auth), H);
    for (int h = 0; h < H; h++) chk("auth_height_seen", 64'(auth_seen[h]), 1);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ctl"}, 64'({busy, leaf_ready, hreq_valid, stk_push, stk_pop, root_valid}), 0);
    chk({tag, "_root_data"}, root_data, 0);
    chk({tag, "_operands"}, {hash_left, hash_right}, 0);
    chk({tag, "_wdata"}, stk_wdata, 0);
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; start = 0;
`ifdef TREEHASH_AUTH_PATH_EN
    auth_idx = '0;
`endif
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1;

    // pin the model with hand-computed values for leaves 1..8, auth_idx=2
    for (int i = 0; i < N; i++) lv[i] = 32'(i + 1);
    aidx_v = 2;
    build_model();
    chk("model_root_1to8", exp_root, 153);
    chk("model_pair2", {exp_pl[2], exp_pr[2]}, {32'd5, 32'd11});
    chk("model_pair6", {exp_pl[6], exp_pr[6]}, {32'd27, 32'd63});
    chk("model_auth_h0_h1", {exp_auth[0], exp_auth[1]}, {32'd4, 32'd5});
    chk("model_auth_h2", exp_auth[2], 63);

    // basic tree, ready always high
    run_tree(0, 0, 2, 0);
    chk("t1_root", last_root, 153);
    chk("t1_pair0", hist[0], {32'd1, 32'd2});
    chk("t1_pair1", hist[1], {32'd3, 32'd4});
    chk("t1_pair2", hist[2], {32'd5, 32'd11});

    // hash unit stalls 5 cycles per request
    run_tree(0, 5, 2, 0);
    chk("t2_root", last_root, 153);

    // leaf gaps, wrapping values, start pokes while busy
    lv[0] = 32'd100;        lv[1] = 32'd7;  lv[2] = 32'hFFFF_FFFF; lv[3] = 32'd3;
    lv[4] = 32'd42;         lv[5] = 32'h8000_0000; lv[6] = 32'd9;  lv[7] = 32'd1;
    run_tree(1, 1, 5, 1);

    // reset during the second hash wait; the late response must be ignored
    for (int i = 0; i < N; i++) lv[i] = 32'(i + 1);
    rsp_dly = 8;
    setup_tree(0, 0, 2);
    begin
      int t;
      t = 0;
      while (n_hreq < 2 && t < 500) begin @(negedge clk); t++; end
      if (n_hreq < 2) chk("reset_test_hreq_timeout", 0, 1);
    end
    @(negedge clk);
    rst_n = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("midtree_reset");
    stk.delete(); lq.delete(); exp_pl.delete(); exp_pr.delete();
    pop_pend = 0; in_req = 0; n_pop = 0; n_root = 0;
    rst_n = 1;
    repeat (10) @(negedge clk);
    chk("no_pop_after_reset", 64'(n_pop), 0);
    chk("idle_after_reset", 64'({busy, root_valid}), 0);
    rsp_dly = 2;
    run_tree(0, 0, 2, 0);
    chk("t4_root", last_root, 153);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/treehash_ctrl.md
TREEHASH_CTRL -- requirements
Module: treehash_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning node/leaf/hash word width.
REQ-002 SHALL have parameter HEIGHT, default 4, meaning tree height; leaf count = 2^HEIGHT; 1 <= HEIGHT <= 16.
REQ-003 SHALL have parameter STK_LAT, default 2, meaning clock cycles from stk_pop pulse to valid stk_rdata.
REQ-004 clock  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse; begins a tree; ignored while busy.
REQ-007 busy  out  1  high from cycle after accepted start until cycle root_valid pulses.
REQ-008 leaf_valid  in  1  leaf source has data.
REQ-009 leaf_ready  out  1  block accepts leaf; transfer when leaf_valid & leaf_ready.
REQ-010 leaf_data  in  DATA_WIDTH  leaf node value.
REQ-011 hash_req_valid  out  1  merge request to hash unit.
REQ-012 hash_req_ready  in  1  hash unit accepts; transfer when both high.
REQ-013 hash_left / hash_right  out  DATA_WIDTH each  left (older, from stack) and right (current) operands.
REQ-014 hash_rsp_valid / hash_rsp_data  in  1 / DATA_WIDTH  one-cycle merged-node result.
REQ-015 stk_push / stk_pop  out  1 each  one-cycle pulses to node stack; never both high.
REQ-016 stk_wdata  out  DATA_WIDTH  push data, valid in stk_push cycle.
REQ-017 stk_rdata  in  DATA_WIDTH  popped value, sampled exactly STK_LAT cycles after stk_pop.
REQ-018 root_valid / root_data  out  1 / DATA_WIDTH  one-cycle pulse with final root.
REQ-019 auth_idx  in  HEIGHT  target leaf index, sampled at accepted start (macro only).
REQ-020 auth_valid / auth_height / auth_data  out  1 / $clog2(HEIGHT)+1 / DATA_WIDTH  auth-path node pulse (macro only).

Function
REQ-021 FSM states: IDLE, LEAF, CHECK, POP, POP_WAIT, HREQ, HWAIT, PUSH, DONE.
REQ-022 IDLE->LEAF on start; leaf counter and internal height stack (HEIGHT entries, own pointer) cleared.
REQ-023 LEAF: leaf_ready=1; on transfer cur<=leaf_data, cur_h<=0, ->CHECK.
REQ-024 CHECK: if height-stack non-empty and top==cur_h ->POP; else if cur_h==HEIGHT ->DONE; else ->PUSH.
REQ-025 POP: stk_pop pulse, height pointer decrements; POP_WAIT counts STK_LAT cycles, latches stk_rdata as left, ->HREQ.
REQ-026 HREQ: hash_req_valid held with stable operands until hash_req_ready; ->HWAIT.
REQ-027 HWAIT: on hash_rsp_valid cur<=hash_rsp_data, cur_h<=cur_h+1, ->CHECK; hash_rsp_valid in other states ignored.
REQ-028 PUSH: stk_push with stk_wdata=cur, push cur_h to height stack, leaf counter++, ->LEAF.
REQ-029 DONE: root_valid=1, root_data=cur for one cycle, busy deasserts same cycle, ->IDLE; node and height stacks empty.
REQ-030 Exactly 2^HEIGHT leaves and 2^HEIGHT-1 hash requests per tree; max stack depth HEIGHT.
REQ-031 start during busy has no effect; leaf_ready=0 outside LEAF.
REQ-032 Leaf counter HEIGHT+1 bits, no wrap within a tree.

Reset
REQ-033 reset low at rising edge: FSM->IDLE, counters/pointers 0, all outputs 0 next cycle, including mid-tree; any in-flight hash response discarded.
REQ-034 External stack reset is owned by integrator; block issues no pops after reset until new start.

Configuration
REQ-035 With TREEHASH_AUTH_PATH_EN defined: whenever cur is formed (leaf or hash result) at height h<HEIGHT with node index (leaf_cnt>>h)==(auth_idx>>h)^1, auth_valid pulses with auth_height=h, auth_data=cur; exactly HEIGHT pulses per tree, ascending-h order not required.
REQ-036 Without TREEHASH_AUTH_PATH_EN: auth_idx, auth_* ports absent; no related logic.

Verification (hash model H(l,r)=l+2r mod 2^32, STK_LAT=2)
REQ-037 HEIGHT=2, leaves 1,2,3,4, ready always high -> hash pairs (1,2),(3,4),(5,11); root_data=27, one root_valid pulse.
REQ-038 HEIGHT=2, hash_req_ready low 5 cycles per request -> operands stable while waiting; root still 27.
REQ-039 HEIGHT=3, leaves 1..8 with leaf_valid gaps -> root matches model; stk_push count 7, stk_pop count 7, never simultaneous.
REQ-040 reset low during 2nd HWAIT, then start with leaves 1,2,3,4 -> root 27, stale hash_rsp ignored.
REQ-041 Macro on, HEIGHT=2, auth_idx=2 -> auth pulses (h=0,data 4),(h=1,data 5).
REQ-042 start pulsed while busy -> no restart; leaf and hash counts unchanged.
